// File: rtl/memgame_pkg.sv
// Shared types and board geometry for the memory-game turn controller.
package memgame_pkg;

   localparam int NCELLS = 16;
   localparam int IW     = 4;
   localparam int LW     = 4;

   // Encoding is exported on state_o, so the values are fixed explicitly.
   typedef enum logic [2:0] {
      ST_PICK1   = 3'd0,
      ST_PICK2   = 3'd1,
      ST_HOLD    = 3'd2,
      ST_RESOLVE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/pair_turn_ctrl_cycle_timer.sv
// Loadable down-counter that stops at zero; done_o flags the zero count.
module cycle_timer #(
   parameter int             W       = 4,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load wins over decrement; the count holds once it reaches zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   // Count register; the reset value lets an idle timer start already armed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= RST_VAL;
      else      cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pair_turn_ctrl.sv
// One turn of the 16-cell memory game: cursor, two picks, hold, resolve,
// player turn, scores and game-over.
module pair_turn_ctrl
   import memgame_pkg::*;
#(
   parameter int NCELLS      = memgame_pkg::NCELLS,
   parameter int IW          = memgame_pkg::IW,
   parameter int LW          = memgame_pkg::LW,
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int TURN_CYCLES = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          move_i,
   input  logic          select_i,
   input  logic [LW-1:0] cur_label_i,
   input  logic          cur_taken_i,
   output logic [IW-1:0] cursor_o,
   output logic [IW-1:0] sel1_o,
   output logic [IW-1:0] sel2_o,
   output logic          reveal_o,
   output logic          hide_o,
   output logic          match_o,
   output logic          player_o,
   output logic [IW-1:0] score0_o,
   output logic [IW-1:0] score1_o,
   output logic          game_over_o,
   output logic [2:0]    state_o
);

   // Timers are loaded with N-1 and act when they read zero, which gives
   // exactly N cycles in the waiting state.
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TURN_LD = TW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
   localparam bit            TO_EN   = (TURN_CYCLES > 0);

   state_e        state_q;
   logic [IW-1:0] cursor_q, sel1_q, sel2_q, score0_q, score1_q, pairs_left_q;
   logic [LW-1:0] label1_q;
   logic          eq_q, player_q, reveal_q, hide_q, match_q, game_over_q;

   logic in_pick, acc1, acc2, accept, timeout;
   logic hold_done, turn_done;

   assign in_pick = (state_q == ST_PICK1) || (state_q == ST_PICK2);
   assign acc1    = (state_q == ST_PICK1) && select_i && !cur_taken_i;
   assign acc2    = (state_q == ST_PICK2) && select_i && !cur_taken_i && (cursor_q != sel1_q);
   assign accept  = acc1 || acc2;
   // An accepted pick on the last idle cycle beats the timeout.
   assign timeout = TO_EN && in_pick && turn_done && !accept;

   cycle_timer #(.W(HW)) u_hold (
      .clk        (clk),
      .rst        (rst),
      .load_i     (acc2),
      .load_val_i (HOLD_LD),
      .dec_i      (state_q == ST_HOLD),
      .done_o     (hold_done)
   );

   // Idle timer restarts on every entry to a pick state (accept, timeout,
   // resolve) and on accepted picks; out of reset it is already armed.
   cycle_timer #(.W(TW), .RST_VAL(TURN_LD)) u_turn (
      .clk        (clk),
      .rst        (rst),
      .load_i     (accept || timeout || (state_q == ST_RESOLVE)),
      .load_val_i (TURN_LD),
      .dec_i      (in_pick),
      .done_o     (turn_done)
   );

   // Turn FSM with its datapath; all pulses are registered and one cycle wide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_PICK1;
         cursor_q     <= '0;
         sel1_q       <= '0;
         sel2_q       <= '0;
         label1_q     <= '0;
         eq_q         <= 1'b0;
         player_q     <= 1'b0;
         score0_q     <= '0;
         score1_q     <= '0;
         pairs_left_q <= IW'(NCELLS / 2);
         reveal_q     <= 1'b0;
         hide_q       <= 1'b0;
         match_q      <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         reveal_q <= 1'b0;
         hide_q   <= 1'b0;
         match_q  <= 1'b0;

         // A select in the same cycle swallows the move.
         if (in_pick && move_i && !select_i)
            cursor_q <= cursor_q + IW'(1);

         case (state_q)
            ST_PICK1: begin
               if (acc1) begin
                  sel1_q   <= cursor_q;
                  label1_q <= cur_label_i;
                  reveal_q <= 1'b1;
                  state_q  <= ST_PICK2;
               end else if (timeout) begin
                  player_q <= ~player_q;
               end
            end
            ST_PICK2: begin
               if (acc2) begin
                  sel2_q   <= cursor_q;
                  eq_q     <= (cur_label_i == label1_q);
                  reveal_q <= 1'b1;
                  state_q  <= ST_HOLD;
               end else if (timeout) begin
                  // Only sel1 is face-up; pointing sel2 at it makes hide_o
                  // turn down just that card.
                  sel2_q   <= sel1_q;
                  hide_q   <= 1'b1;
                  player_q <= ~player_q;
                  state_q  <= ST_PICK1;
               end
            end
            ST_HOLD: begin
               if (hold_done) state_q <= ST_RESOLVE;
            end
            ST_RESOLVE: begin
               if (eq_q) begin
                  match_q      <= 1'b1;
                  pairs_left_q <= pairs_left_q - IW'(1);
                  if (player_q) score1_q <= score1_q + IW'(1);
                  else          score0_q <= score0_q + IW'(1);
                  if (pairs_left_q == IW'(1)) begin
                     game_over_q <= 1'b1;
                     state_q     <= ST_DONE;
                  end else begin
                     state_q <= ST_PICK1;
                  end
               end else begin
                  hide_q   <= 1'b1;
                  player_q <= ~player_q;
                  state_q  <= ST_PICK1;
               end
            end
            ST_DONE: state_q <= ST_DONE;
            default: state_q <= ST_PICK1;
         endcase
      end
   end

   assign cursor_o    = cursor_q;
   assign sel1_o      = sel1_q;
   assign sel2_o      = sel2_q;
   assign reveal_o    = reveal_q;
   assign hide_o      = hide_q;
   assign match_o     = match_q;
   assign player_o    = player_q;
   assign score0_o    = score0_q;
   assign score1_o    = score1_q;
   assign game_over_o = game_over_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_pair_turn_ctrl.sv
// Directed bench for pair_turn_ctrl with HOLD_CYCLES=4, TURN_CYCLES=20.
module tb_pair_turn_ctrl;

   localparam int S_P1 = 0, S_P2 = 1, S_HOLD = 2, S_RES = 3, S_DONE = 4;

   logic       clk = 1'b0, rst = 1'b0, move_i = 1'b0, select_i = 1'b0;
   logic [3:0] cur_label_i;
   logic       cur_taken_i;
   logic [3:0] cursor_o, sel1_o, sel2_o, score0_o, score1_o;
   logic       reveal_o, hide_o, match_o, player_o, game_over_o;
   logic [2:0] state_o;

   logic [3:0]  labels [16] = '{4'd1, 4'd3, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                4'd6, 4'd3, 4'd7, 4'd4, 4'd8, 4'd1, 4'd5, 4'd2};
   logic [15:0] taken = '0;

   int n_cmp = 0, n_err = 0;
   int exp_cur = 0, exp_s0 = 0;

   // Cell array model: combinational label/taken lookup at the cursor.
   assign cur_label_i = labels[cursor_o];
   assign cur_taken_i = taken[cursor_o];

   pair_turn_ctrl #(.HOLD_CYCLES(4), .TURN_CYCLES(20)) dut (
      .clk(clk), .rst(rst), .move_i(move_i), .select_i(select_i),
      .cur_label_i(cur_label_i), .cur_taken_i(cur_taken_i),
      .cursor_o(cursor_o), .sel1_o(sel1_o), .sel2_o(sel2_o),
      .reveal_o(reveal_o), .hide_o(hide_o), .match_o(match_o),
      .player_o(player_o), .score0_o(score0_o), .score1_o(score1_o),
      .game_over_o(game_over_o), .state_o(state_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic mv(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); move_i = 1'b1;
      end
      if (n > 0) begin
         @(negedge clk); move_i = 1'b0;
      end
      exp_cur = (exp_cur + n) % 16;
   endtask

   task automatic sel();
      @(negedge clk); select_i = 1'b1;
      @(negedge clk); select_i = 1'b0;
   endtask

   task automatic goto(input int n);
      mv((n - exp_cur + 16) % 16);
      chk("cursor_goto", int'(cursor_o), n);
   endtask

   task automatic reset_dut();
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_cur = 0; exp_s0 = 0; taken = '0;
   endtask

   // Player 0 picks a matching pair a,b and wins it.
   task automatic do_pair(input int a, input int b, input int final_state);
      goto(a); sel();
      chk("pair_reveal1", int'(reveal_o), 1);
      goto(b); sel();
      chk("pair_reveal2", int'(reveal_o), 1);
      chk("pair_hold", int'(state_o), S_HOLD);
      repeat (5) @(negedge clk);
      exp_s0++;
      chk("pair_match", int'(match_o), 1);
      chk("pair_score0", int'(score0_o), exp_s0);
      chk("pair_state", int'(state_o), final_state);
      taken[a] = 1'b1; taken[b] = 1'b1;
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_cursor", int'(cursor_o), 0);
      chk("rst_sel1", int'(sel1_o), 0);
      chk("rst_sel2", int'(sel2_o), 0);
      chk("rst_player", int'(player_o), 0);
      chk("rst_score0", int'(score0_o), 0);
      chk("rst_score1", int'(score1_o), 0);
      chk("rst_game_over", int'(game_over_o), 0);
      chk("rst_state", int'(state_o), S_P1);
      chk("rst_pulses", int'({reveal_o, hide_o, match_o}), 0);
      rst = 1'b1;

      // Cursor wrap, then PICK1 idle timeout on the 20th cycle after release
      mv(16);
      chk("wrap16", int'(cursor_o), 0);
      mv(1);
      chk("wrap17", int'(cursor_o), 1);
      chk("p1_before_to", int'(player_o), 0);
      @(negedge clk);
      chk("p1_timeout", int'(player_o), 1);
      reset_dut();
      chk("rst2_player", int'(player_o), 0);

      // Matching pair 0/13
      sel();
      chk("m_reveal1", int'(reveal_o), 1);
      chk("m_sel1", int'(sel1_o), 0);
      chk("m_state_p2", int'(state_o), S_P2);
      goto(13); sel();
      chk("m_reveal2", int'(reveal_o), 1);
      chk("m_sel2", int'(sel2_o), 13);
      chk("m_state_hold", int'(state_o), S_HOLD);
      @(negedge clk);
      chk("m_reveal_width", int'(reveal_o), 0);
      repeat (2) @(negedge clk);
      chk("m_hold4", int'(state_o), S_HOLD);
      @(negedge clk);
      chk("m_resolve", int'(state_o), S_RES);
      @(negedge clk);
      chk("m_match", int'(match_o), 1);
      chk("m_score0", int'(score0_o), 1);
      chk("m_player", int'(player_o), 0);
      chk("m_state_p1", int'(state_o), S_P1);
      @(negedge clk);
      chk("m_match_width", int'(match_o), 0);
      exp_s0 = 1; taken[0] = 1'b1; taken[13] = 1'b1;

      // Mismatch 1/2
      goto(1); sel();
      goto(2); sel();
      chk("x_hold", int'(state_o), S_HOLD);
      repeat (5) @(negedge clk);
      chk("x_hide", int'(hide_o), 1);
      chk("x_match", int'(match_o), 0);
      chk("x_player", int'(player_o), 1);
      chk("x_score0", int'(score0_o), 1);
      chk("x_score1", int'(score1_o), 0);
      chk("x_state", int'(state_o), S_P1);
      @(negedge clk);
      chk("x_hide_width", int'(hide_o), 0);

      // Same cell twice, then PICK2 timeout
      sel();
      chk("d_reveal1", int'(reveal_o), 1);
      chk("d_sel1", int'(sel1_o), 2);
      sel();
      chk("d_reveal_dup", int'(reveal_o), 0);
      chk("d_state_dup", int'(state_o), S_P2);
      repeat (17) @(negedge clk);
      chk("t_before", int'(state_o), S_P2);
      chk("t_before_hide", int'(hide_o), 0);
      @(negedge clk);
      chk("t_state", int'(state_o), S_P1);
      chk("t_hide", int'(hide_o), 1);
      chk("t_player", int'(player_o), 0);
      chk("t_sel2", int'(sel2_o), 2);

      // Move and select together: select at current cursor, move dropped
      @(negedge clk); move_i = 1'b1; select_i = 1'b1;
      @(negedge clk); move_i = 1'b0; select_i = 1'b0;
      chk("ms_reveal", int'(reveal_o), 1);
      chk("ms_sel1", int'(sel1_o), 2);
      chk("ms_cursor", int'(cursor_o), 2);
      goto(15); sel();
      repeat (5) @(negedge clk);
      exp_s0++;
      chk("ms_match", int'(match_o), 1);
      chk("ms_score0", int'(score0_o), exp_s0);
      taken[2] = 1'b1; taken[15] = 1'b1;

      // Select on a taken cell in PICK1
      sel();
      chk("tk_reveal", int'(reveal_o), 0);
      chk("tk_state", int'(state_o), S_P1);
      chk("tk_sel1", int'(sel1_o), 2);

      // Remaining pairs to game over
      do_pair(1, 9, S_P1);
      do_pair(3, 11, S_P1);
      do_pair(4, 14, S_P1);
      do_pair(5, 8, S_P1);
      do_pair(6, 10, S_P1);
      do_pair(7, 12, S_DONE);
      chk("go_flag", int'(game_over_o), 1);
      chk("go_score1", int'(score1_o), 0);
      repeat (3) begin
         @(negedge clk); move_i = 1'b1;
      end
      @(negedge clk); move_i = 1'b0;
      sel();
      chk("go_cursor", int'(cursor_o), 12);
      chk("go_state", int'(state_o), S_DONE);
      chk("go_reveal", int'(reveal_o), 0);
      chk("go_score0", int'(score0_o), 8);
      chk("go_flag2", int'(game_over_o), 1);

      // Reset during HOLD
      reset_dut();
      sel();
      goto(13); sel();
      chk("rh_hold", int'(state_o), S_HOLD);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rh_state", int'(state_o), S_P1);
      chk("rh_cursor", int'(cursor_o), 0);
      chk("rh_sels", int'({sel1_o, sel2_o}), 0);
      chk("rh_scores", int'({score0_o, score1_o}), 0);
      chk("rh_misc", int'({reveal_o, hide_o, match_o, player_o, game_over_o}), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rh_no_pulse", int'({hide_o, match_o}), 0);
         chk("rh_stay_p1", int'(state_o), S_P1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
